corevx_mem_responder: RTL and testbench

Synthesizable memory-side responder for the corevx cache memory bus (m_* interface). It accepts single and burst read and write requests from the cache, an initiator that drives m_address/m_burstcount/m_read/m_write. It serves them from an internal word array and returns per-beat OKAY/error responses. It sits at the memory end of the cache port and serves as on-chip RAM for FPGA builds and as the reference slave for cache benches.

---
 rtl/corevx_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_corevx_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/corevx_mem_responder.sv
// Memory-side responder for the corevx cache bus: serves single/burst reads and
// writes from an internal word array with per-beat OKAY/error responses.
module corevx_mem_responder #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m_address,
  input  logic [4:0]        m_burstcount,
  input  logic              m_read,
  input  logic              m_write,
  input  logic [31:0]       m_writedata,
  input  logic [3:0]        m_byteenable,
  output logic              m_waitrequest,
  output logic              m_readdatavalid,
  output logic [31:0]       m_readdata,
  output logic [1:0]        m_response
);

  localparam int unsigned WI_W = ADDR_W - 2;
  localparam int unsigned BA_W = WI_W + 1;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_RESP  = 2'd2,
    WR_WAIT  = 2'd3
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [BA_W-1:0] base_q, base_d;
  logic [4:0]      beat_q, beat_d;
  logic [4:0]      count_q, count_d;
  logic            wait_d, rdv_d;
  logic [1:0]      resp_d;

  logic [BA_W-1:0] req_addr_c, cur_addr_c, nxt_addr_c;
  logic [BA_W-1:0] rd_addr_c, wr_addr_c;
  logic            rd_en_c, we_c, last_c;
  logic [5:0]      count_eff_c;
  logic            unused_addr_lo_c;

  function automatic logic in_range(input logic [BA_W-1:0] a);
    return a < BA_W'(DEPTH);
  endfunction

  assign unused_addr_lo_c = ^m_address[1:0];
  assign req_addr_c  = BA_W'(m_address[ADDR_W-1:2]);
  assign cur_addr_c  = base_q + BA_W'(beat_q);
  assign nxt_addr_c  = base_q + BA_W'(beat_q) + BA_W'(1);
  // A zero burstcount is treated as a single (error) beat.
  assign count_eff_c = (count_q == 5'd0) ? 6'd1 : 6'(count_q);
  assign last_c      = (6'(beat_q) + 6'd1) >= count_eff_c;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beat_d    = beat_q;
    count_d   = count_q;
    wait_d    = 1'b1;
    rdv_d     = 1'b0;
    resp_d    = RESP_ERR;
    rd_addr_c = cur_addr_c;
    wr_addr_c = cur_addr_c;
    rd_en_c   = 1'b0;
    we_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_read) begin
          base_d    = req_addr_c;
          beat_d    = 5'd0;
          count_d   = m_burstcount;
          rd_addr_c = req_addr_c;
          rd_en_c   = in_range(req_addr_c) && (m_burstcount != 5'd0);
          rdv_d     = 1'b1;
          wait_d    = 1'b0;
          resp_d    = rd_en_c ? RESP_OKAY : RESP_ERR;
          state_d   = RD_BURST;
        end else if (m_write) begin
          base_d    = req_addr_c;
          beat_d    = 5'd0;
          count_d   = m_burstcount;
          wr_addr_c = req_addr_c;
          we_c      = in_range(req_addr_c) && (m_burstcount != 5'd0);
          wait_d    = 1'b0;
          resp_d    = we_c ? RESP_OKAY : RESP_ERR;
          state_d   = WR_RESP;
        end
      end
      RD_BURST: begin
        if (last_c) begin
          state_d = IDLE;
        end else begin
          beat_d    = beat_q + 5'd1;
          rd_addr_c = nxt_addr_c;
          rd_en_c   = in_range(nxt_addr_c);
          rdv_d     = 1'b1;
          resp_d    = rd_en_c ? RESP_OKAY : RESP_ERR;
        end
      end
      WR_RESP: begin
        if (last_c) begin
          state_d = IDLE;
        end else begin
          beat_d  = beat_q + 5'd1;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (m_write) begin
          wr_addr_c = cur_addr_c;
          we_c      = in_range(cur_addr_c);
          wait_d    = 1'b0;
          resp_d    = we_c ? RESP_OKAY : RESP_ERR;
          state_d   = WR_RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      beat_q          <= '0;
      count_q         <= '0;
      m_waitrequest   <= 1'b1;
      m_readdatavalid <= 1'b0;
      m_readdata      <= '0;
      m_response      <= RESP_ERR;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      beat_q          <= beat_d;
      count_q         <= count_d;
      m_waitrequest   <= wait_d;
      m_readdatavalid <= rdv_d;
      m_readdata      <= rd_en_c ? mem[rd_addr_c[AW-1:0]] : 32'd0;
      m_response      <= resp_d;
    end
  end

  // Byte-lane array writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && we_c && m_byteenable[i]) begin
        mem[wr_addr_c[AW-1:0]][8*i +: 8] <= m_writedata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_corevx_mem_responder.sv
// Scoreboard bench for corevx_mem_responder: drivers queue expected beats,
// a negedge monitor pops and compares whenever the responder presents a response.
module tb_corevx_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [33:0] m_address = '0;
  logic [4:0]  m_burstcount = '0;
  logic        m_read = 1'b0;
  logic        m_write = 1'b0;
  logic [31:0] m_writedata = '0;
  logic [3:0]  m_byteenable = '0;
  logic        m_waitrequest;
  logic        m_readdatavalid;
  logic [31:0] m_readdata;
  logic [1:0]  m_response;

  corevx_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .m_address(m_address), .m_burstcount(m_burstcount),
    .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
    .m_readdata(m_readdata), .m_response(m_response)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        first;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic [1:0]  wq[$];
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;
  logic [31:0] wdata [16];
  logic [3:0]  wbe [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every response cycle is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_readdatavalid) begin
        if (rq.size() == 0) begin
          fail_now("unexpected_read_beat");
        end else begin
          rd_exp_t e;
          e = rq.pop_front();
          check("rd_data", m_readdata, e.data);
          check("rd_resp", 32'(m_response), 32'(e.resp));
          check("rd_waitreq", 32'(m_waitrequest), e.first ? 32'd0 : 32'd1);
        end
      end else if (!m_waitrequest) begin
        if (wq.size() == 0) fail_now("unexpected_write_resp");
        else check("wr_resp", 32'(m_response), 32'(wq.pop_front()));
      end else begin
        check("idle_resp", 32'(m_response), 32'd3);
      end
    end
  end

  task automatic push_rd(input logic [31:0] d, input logic [1:0] r, input logic f);
    rd_exp_t e;
    e.data = d; e.resp = r; e.first = f;
    rq.push_back(e);
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_waitrequest && n < 20);
    if (m_waitrequest) fail_now(name);
  endtask

  task automatic req_read(input logic [33:0] addr, input logic [4:0] bc, input logic also_wr);
    m_address = addr; m_burstcount = bc;
    m_writedata = 32'hFFFF_FFFF; m_byteenable = 4'hF;
    m_read = 1'b1; m_write = also_wr;
    wait_accept("rd_accept_timeout");
    m_read = 1'b0; m_write = 1'b0;
    repeat ((bc == 5'd0) ? 1 : int'(bc)) @(negedge clk);
  endtask

  task automatic req_write(input logic [33:0] addr, input logic [4:0] bc);
    m_address = addr; m_burstcount = bc;
    for (int i = 0; i < ((bc == 5'd0) ? 1 : int'(bc)); i++) begin
      m_writedata = wdata[i]; m_byteenable = wbe[i]; m_write = 1'b1;
      wait_accept("wr_accept_timeout");
      m_write = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic write1(input logic [33:0] addr, input logic [31:0] d,
                        input logic [3:0] be, input logic [1:0] r);
    wdata[0] = d; wbe[0] = be;
    wq.push_back(r);
    req_write(addr, 5'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_waitreq", 32'(m_waitrequest), 32'd1);
    check("rst_rdvalid", 32'(m_readdatavalid), 32'd0);
    check("rst_rdata", m_readdata, 32'd0);
    check("rst_resp", 32'(m_response), 32'd3);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single read
    write1(34'h0, 32'hBEAF_DEAD, 4'hF, 2'b00);
    push_rd(32'hBEAF_DEAD, 2'b00, 1'b1);
    req_read(34'h0, 5'd1, 1'b0);

    // 16-beat write then read at word 16
    for (int i = 0; i < 16; i++) begin
      wdata[i] = 32'(16 + i); wbe[i] = 4'hF; wq.push_back(2'b00);
    end
    req_write(34'h40, 5'd16);
    for (int i = 0; i < 16; i++) push_rd(32'(16 + i), 2'b00, i == 0);
    req_read(34'h40, 5'd16, 1'b0);

    // Byte enables
    write1(34'h4, 32'h0, 4'hF, 2'b00);
    write1(34'h4, 32'hABCD_1234, 4'b0101, 2'b00);
    push_rd(32'h00CD_0034, 2'b00, 1'b1);
    req_read(34'h4, 5'd1, 1'b0);

    // Read and write together: read wins, word unchanged
    push_rd(32'h00CD_0034, 2'b00, 1'b1);
    req_read(34'h4, 5'd1, 1'b1);
    push_rd(32'h00CD_0034, 2'b00, 1'b1);
    req_read(34'h4, 5'd1, 1'b0);

    // Write burst of 4 at 0x100
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'hA0 + 32'(i); wbe[i] = 4'hF; wq.push_back(2'b00);
    end
    req_write(34'h100, 5'd4);
    for (int i = 0; i < 4; i++) push_rd(32'hA0 + 32'(i), 2'b00, i == 0);
    req_read(34'h100, 5'd4, 1'b0);

    // Out of range: words 4094..4097
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'h1111_0000 + 32'(i); wbe[i] = 4'hF;
      wq.push_back((i < 2) ? 2'b00 : 2'b11);
    end
    req_write(34'h3FF8, 5'd4);
    push_rd(32'h1111_0000, 2'b00, 1'b1);
    push_rd(32'h1111_0001, 2'b00, 1'b0);
    push_rd(32'h0, 2'b11, 1'b0);
    push_rd(32'h0, 2'b11, 1'b0);
    req_read(34'h3FF8, 5'd4, 1'b0);

    // Burstcount 0: single error beat, no array write
    push_rd(32'h0, 2'b11, 1'b1);
    req_read(34'h0, 5'd0, 1'b0);
    write1(34'h8, 32'h2222_2222, 4'hF, 2'b00);
    wdata[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF; wq.push_back(2'b11);
    req_write(34'h8, 5'd0);
    push_rd(32'h2222_2222, 2'b00, 1'b1);
    req_read(34'h8, 5'd1, 1'b0);

    // Reset after beat 3 of an 8-beat read
    for (int i = 0; i < 4; i++) push_rd(32'(16 + i), 2'b00, i == 0);
    m_address = 34'h40; m_burstcount = 5'd8; m_read = 1'b1;
    wait_accept("rd_accept_timeout");
    m_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rdvalid", 32'(m_readdatavalid), 32'd0);
    check("midrst_waitreq", 32'(m_waitrequest), 32'd1);
    check("midrst_resp", 32'(m_response), 32'd3);
    rst_n = 1'b1;
    @(negedge clk);
    push_rd(32'd16, 2'b00, 1'b1);
    req_read(34'h40, 5'd1, 1'b0);

    repeat (3) @(negedge clk);
    check("rd_queue_left", 32'(rq.size()), 32'd0);
    check("wr_queue_left", 32'(wq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
